// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit limit,
// buffers returned instructions with their PCs and drops stale responses after a redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SW = CW + 2;

   logic [31:0]   req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   pc_mem_q   [DEPTH];

   logic [31:0]   target_aligned;
   logic [SW-1:0] credit_used, stale_sum;
   logic          req_fire, resp_drop, resp_push, pop;

   function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Every slot a request could end up in (in flight, to be dropped, or buffered) counts against DEPTH.
   assign credit_used    = SW'(outst_q) + SW'(discard_q) + SW'(count_q);
   assign stale_sum      = SW'(discard_q) + SW'(outst_q);
   assign target_aligned = redirect_target_i & 32'hFFFF_FFFC;

   assign imem_req_o   = rst_n_i && !redirect_i && (credit_used < SW'(DEPTH));
   assign imem_addr_o  = req_pc_q;
   assign req_fire     = imem_req_o && imem_ready_i;
   assign resp_drop    = imem_rvalid_i && (discard_q != '0);
   assign resp_push    = imem_rvalid_i && (discard_q == '0) && (outst_q != '0);

   assign inst_valid_o = rst_n_i && (count_q != '0);
   assign pop          = inst_valid_o && inst_ready_i;
   assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : '0;
   assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q]   : '0;

   always_comb begin
      req_pc_d  = req_pc_q;
      resp_pc_d = resp_pc_q;
      outst_d   = outst_q;
      discard_d = discard_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (redirect_i) begin
         // A response landing in the redirect cycle belongs to the old stream.
         req_pc_d  = target_aligned;
         resp_pc_d = target_aligned;
         outst_d   = '0;
         count_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         discard_d = (imem_rvalid_i && (stale_sum != '0)) ? CW'(stale_sum - 1'b1) : CW'(stale_sum);
      end else begin
         if (req_fire) begin
            req_pc_d = req_pc_q + 32'd4;
         end
         if (resp_drop) begin
            discard_d = discard_q - 1'b1;
         end
         if (resp_push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = ptrInc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptrInc(rd_ptr_q);
         end
         outst_d = outst_q + CW'(req_fire) - CW'(resp_push);
         count_d = count_q + CW'(resp_push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         req_pc_q  <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outst_q   <= '0;
         discard_q <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         req_pc_q  <= req_pc_d;
         resp_pc_q <= resp_pc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i && !redirect_i && resp_push) begin
         inst_mem_q[wr_ptr_q] <= imem_rdata_i;
         pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for streaming/backpressure,
// a redirect-target table, and hand sequences for stale-response, back-to-back and reset cases.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_n_i, redirect_i, imem_req_o, imem_ready_i, imem_rvalid_i;
   logic        inst_valid_o, inst_ready_i;
   logic [31:0] redirect_target_i, imem_addr_o, imem_rdata_i, inst_o, inst_pc_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lat    = 1;

   typedef struct { int due; logic [31:0] data; } resp_t;
   resp_t memQ[$];

   typedef struct {
      logic        rdy;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;
   vec_t vecs[21];

   typedef struct { logic [31:0] tgt; logic [31:0] expAddr; logic [31:0] expPc2; } rvec_t;
   rvec_t rvecs[4];

   always #5 clk_i = ~clk_i;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
      .inst_ready_i(inst_ready_i)
   );

   function automatic logic [31:0] mkData(input logic [31:0] a);
      return a ^ 32'hC0DE_5A5A;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst_n, input logic redir, input logic [31:0] tgt,
                                input logic rdy);
      rst_n_i           = rst_n;
      redirect_i        = redir;
      redirect_target_i = tgt;
      inst_ready_i      = rdy;
      #1;
   endtask

   // One clock: memory model sees the accepted request, then drives the in-order response stream.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      acc = imem_req_o && imem_ready_i;
      a   = imem_addr_o;
      @(posedge clk_i);
      #1;
      cyc++;
      if (!rst_n_i) memQ.delete();
      else if (acc) memQ.push_back('{due: cyc + lat - 1, data: mkData(a)});
      if (memQ.size() > 0 && memQ[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = memQ[0].data;
         void'(memQ.pop_front());
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
      end
      #1;
   endtask

   task automatic waitValid(input string name, input logic [31:0] expPc, input int expWait);
      int n = 0;
      while (!inst_valid_o && n < 20) begin
         tick();
         n++;
      end
      checkOutput({name, "_wait"}, 32'(n), 32'(expWait));
      checkOutput({name, "_pc"}, inst_pc_o, expPc);
      checkOutput({name, "_data"}, inst_o, mkData(expPc));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      vecs[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
      vecs[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
      for (int i = 7; i <= 14; i++) vecs[i] = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
      vecs[15] = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
      vecs[16] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
      vecs[17] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
      vecs[18] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
      vecs[19] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
      vecs[20] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

      rvecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
      rvecs[1] = '{32'h0000_0207, 32'h0000_0204, 32'h0000_0208};
      rvecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
      rvecs[3] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0004};

      imem_ready_i  = 1'b1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) tick();
      checkOutput("rst_req", 32'(imem_req_o), 32'd0);
      checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("rst_inst", inst_o, 32'd0);
      checkOutput("rst_pc", inst_pc_o, 32'd0);
      checkOutput("rst_addr", imem_addr_o, RESET_PC);

      // Streaming from reset, then 10 cycles of decode backpressure and release.
      for (int i = 0; i < 21; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, vecs[i].rdy);
         checkOutput($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(vecs[i].expReq));
         checkOutput($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d_valid", i), 32'(inst_valid_o), 32'(vecs[i].expValid));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d_pc", i), inst_pc_o, vecs[i].expPc);
            checkOutput($sformatf("vec%0d_data", i), inst_o, mkData(vecs[i].expPc));
         end
         tick();
      end

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, rvecs[i].tgt, 1'b1);
         checkOutput($sformatf("rd%0d_noreq", i), 32'(imem_req_o), 32'd0);
         tick();
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
         checkOutput($sformatf("rd%0d_req", i), 32'(imem_req_o), 32'd1);
         checkOutput($sformatf("rd%0d_addr", i), imem_addr_o, rvecs[i].expAddr);
         waitValid($sformatf("rd%0d_first", i), rvecs[i].expAddr, 2);
         tick();
         waitValid($sformatf("rd%0d_second", i), rvecs[i].expPc2, 0);
      end

      // Redirect in a cycle that also has a response and a decode pop.
      applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b1);
      checkOutput("rvp_noreq", 32'(imem_req_o), 32'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("rvp_flush_empty", 32'(inst_valid_o), 32'd0);
      checkOutput("rvp_addr", imem_addr_o, 32'h0000_0300);
      waitValid("rvp_first", 32'h0000_0300, 2);

      applyStimulus(1'b1, 1'b1, 32'h0000_0040, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h0000_0080, 1'b1);
      checkOutput("b2b_noreq", 32'(imem_req_o), 32'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("b2b_addr", imem_addr_o, 32'h0000_0080);
      waitValid("b2b_first", 32'h0000_0080, 2);

      // Latency 3: redirect while two requests are in flight; both responses must be dropped.
      lat = 3;
      applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("l3_addr0", imem_addr_o, 32'h0000_0200);
      tick();
      checkOutput("l3_addr1", imem_addr_o, 32'h0000_0204);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1);
      checkOutput("l3_noreq", 32'(imem_req_o), 32'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("l3_addr_tgt", imem_addr_o, 32'h0000_0100);
      checkOutput("l3_valid_gone", 32'(inst_valid_o), 32'd0);
      waitValid("l3_first", 32'h0000_0100, 4);
      tick();
      waitValid("l3_second", 32'h0000_0104, 0);

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (2) tick();

      // Fill under backpressure with latency 3, then reset mid-transfer.
      applyStimulus(1'b1, 1'b1, 32'h0000_0400, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (4) tick();
      checkOutput("full_noreq", 32'(imem_req_o), 32'd0);
      tick();
      checkOutput("prerst_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("prerst_pc", inst_pc_o, 32'h0000_0400);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkOutput("midrst_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("midrst_req", 32'(imem_req_o), 32'd0);
      checkOutput("midrst_inst", inst_o, 32'd0);
      checkOutput("midrst_pc", inst_pc_o, 32'd0);
      tick();
      lat = 1;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("restart_req", 32'(imem_req_o), 32'd1);
      checkOutput("restart_addr", imem_addr_o, RESET_PC);
      waitValid("restart_first", RESET_PC, 2);
      tick();
      waitValid("restart_second", RESET_PC + 32'd4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
